// File: rtl/hero_pkg.sv
// rtl/hero_pkg.sv - hero bus beat type shared by hero write sources and sinks
package hero_pkg;

  localparam int HERO_WIDTH = 36;

  typedef enum logic [3:0] {
    _E_IDLE  = 4'd0,
    _E_VALID = 4'd1,
    _E_DONE  = 4'd2
  } CYCLE_TYPE_E;

  typedef struct packed {
    CYCLE_TYPE_E             cycle_type;
    logic [HERO_WIDTH-1:0]   wdat;
    logic                    clk_en;
  } hero_write_t;

endpackage

// File: rtl/hero_write_arb_pkg.sv
// rtl/hero_write_arb_pkg.sv - states and constants for the hero write arbiter
package hero_write_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } ARB_STATE_E;

  localparam int HERO_WRITE_ARB_NUM_REQ = 4;
  localparam int HERO_WRITE_ARB_TO_W    = 16;

endpackage

// File: rtl/hero_rr_pick.sv
// rtl/hero_rr_pick.sv - rotating-priority picker: first set req at or after ptr, wrapping
module hero_rr_pick
  import hero_write_arb_pkg::*;
#(
  parameter int N = HERO_WRITE_ARB_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  // Walk offsets from far to near so the nearest hit to ptr wins last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
    end
  end

  assign any = |req;

endmodule

// File: rtl/hero_write_arb.sv
// rtl/hero_write_arb.sv - round-robin hero write bus arbiter with registered output beat
// Optional stall watchdog enabled by defining HERO_WRITE_ARB_TIMEOUT_EN.
module hero_write_arb
  import hero_write_arb_pkg::*;
#(
  parameter int NUM_REQ        = HERO_WRITE_ARB_NUM_REQ,
  parameter int HERO_WIDTH     = hero_pkg::HERO_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*(HERO_WIDTH+5)-1:0] req_beat,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              hero_valid,
  output logic [HERO_WIDTH+4:0]             hero_beat,
  input  logic                              hero_ready,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              proto_err,
  output logic                              timeout_err
);
  localparam int BW = HERO_WIDTH + 5;
  localparam int IW = $clog2(NUM_REQ);

  ARB_STATE_E            state, state_n;
  logic [IW-1:0]         rr_ptr, pick_idx, next_ptr;
  logic                  pick_any, out_space, accept, load, advance, set_proto;
  logic                  to_hit, to_fire;
  hero_pkg::hero_write_t cur_beat, load_beat, out_q;

  hero_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign cur_beat  = req_beat[int'(grant_id)*BW +: BW];
  assign out_space = !hero_valid || hero_ready;
  assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy      = (state == XFER);
  assign hero_beat = out_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_n;
  end

  always_comb begin
    state_n          = state;
    req_ready        = '0;
    accept           = 1'b0;
    load             = 1'b0;
    advance          = 1'b0;
    set_proto        = 1'b0;
    load_beat        = cur_beat;
    load_beat.clk_en = 1'b1;
    case (state)
      ARB: if (pick_any) state_n = XFER;
      XFER: begin
        if (!to_hit) begin
          req_ready[grant_id] = out_space;
          accept              = req_valid[grant_id] && out_space;
        end
        set_proto = req_valid[grant_id] && (cur_beat.cycle_type == hero_pkg::_E_IDLE);
        // IDLE beats are swallowed: consumed from the owner, never forwarded.
        load = accept && (cur_beat.cycle_type != hero_pkg::_E_IDLE);
        if (accept && cur_beat.cycle_type == hero_pkg::_E_DONE) begin
          state_n = ARB;
          advance = 1'b1;
        end
        if (to_fire) begin
          load      = 1'b1;
          load_beat = '{cycle_type: hero_pkg::_E_DONE, wdat: '0, clk_en: 1'b1};
          state_n   = ARB;
          advance   = 1'b1;
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      hero_valid <= 1'b0;
      out_q      <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (state == ARB && pick_any) grant_id <= pick_idx;
      if (advance) rr_ptr <= next_ptr;
      if (load) begin
        out_q      <= load_beat;
        hero_valid <= 1'b1;
      end else if (hero_ready) begin
        hero_valid <= 1'b0;
      end
      if (set_proto) proto_err <= 1'b1;
    end
  end

`ifdef HERO_WRITE_ARB_TIMEOUT_EN
  logic [HERO_WRITE_ARB_TO_W-1:0] to_cnt;

  // Once the limit is hit the owner is locked out and a DONE is injected when space frees.
  assign to_hit  = (state == XFER) && (to_cnt >= HERO_WRITE_ARB_TO_W'(TIMEOUT_CYCLES));
  assign to_fire = to_hit && out_space;

  always_ff @(posedge clk) begin
    if (rst || state != XFER || accept) to_cnt <= '0;
    else if (!req_valid[grant_id] && !to_hit) to_cnt <= to_cnt + 1'b1;
    if (rst) timeout_err <= 1'b0;
    else if (to_fire) timeout_err <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > HERO_WRITE_ARB_TO_W);
  assign to_hit      = 1'b0;
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hero_write_arb.sv
// tb/tb_hero_write_arb.sv - scoreboard bench for hero_write_arb (directed vectors)
module tb_hero_write_arb;
  localparam int NUM_REQ = 4;
  localparam int HW      = 36;
  localparam int BW      = HW + 5;
  localparam logic [3:0] T_IDLE  = 4'd0;
  localparam logic [3:0] T_VALID = 4'd1;
  localparam logic [3:0] T_DONE  = 4'd2;

  logic                  clk, rst, hero_valid, hero_ready, busy, proto_err, timeout_err;
  logic [NUM_REQ-1:0]    req_valid, req_ready, acc;
  logic [NUM_REQ*BW-1:0] req_beat;
  logic [BW-1:0]         hero_beat, held;
  logic [1:0]            grant_id;

  logic [BW-1:0] rq [NUM_REQ][$];
  logic [BW-1:0] exp_q [$];
  int            beat_cyc [$];
  int            checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
  bit            stalled_prev = 0;

  hero_write_arb #(.NUM_REQ(NUM_REQ), .HERO_WIDTH(HW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_beat(req_beat), .req_ready(req_ready),
    .hero_valid(hero_valid), .hero_beat(hero_beat), .hero_ready(hero_ready),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] mk(input logic [3:0] t, input logic [HW-1:0] d, input logic ce);
    return {t, d, ce};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int r, input logic [3:0] t, input logic [HW-1:0] d, input logic ce);
    rq[r].push_back(mk(t, d, ce));
  endtask

  task automatic expect_beat(input logic [3:0] t, input logic [HW-1:0] d);
    exp_q.push_back(mk(t, d, 1'b1));
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b1;
    return (exp_q.size() != 0) || busy || hero_valid;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (pending() && n < 300) begin
      @(negedge clk); #3;
      n++;
    end
    check(name, n < 300, 1'b1);
  endtask

  task automatic wait_beats(input int want, input string name);
    int n = 0;
    while (beat_cyc.size() < want && n < 100) begin
      @(negedge clk); #3;
      n++;
    end
    check(name, beat_cyc.size() >= want, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk); #3;
    rst = 0;
  endtask

  // Requester driver: inputs change only on negedge; handshakes are latched just after.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(rq[i].pop_front());
    end
    hero_ready = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]           = (rq[i].size() != 0);
      req_beat[i*BW +: BW]   = (rq[i].size() != 0) ? rq[i][0] : '0;
    end
    #1;
    acc = rst ? '0 : (req_valid & req_ready);
  end

  // Output monitor: pops the scoreboard on every downstream handshake.
  always @(negedge clk) begin
    logic [BW-1:0] e;
    #2;
    cyc++;
    if (rst) begin
      stalled_prev = 0;
    end else begin
      if (stalled_prev) begin
        check("hold_valid", hero_valid, 1'b1);
        check("hold_beat", hero_beat, held);
      end
      if (hero_valid && hero_ready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", hero_beat);
        end else begin
          e = exp_q.pop_front();
          check("hero_beat", hero_beat, e);
        end
      end
      stalled_prev = hero_valid && !hero_ready;
      held         = hero_beat;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; req_valid = '0; req_beat = '0; hero_ready = 1; acc = '0;
    @(negedge clk);
    @(negedge clk); #3;
    check("rst_hero_valid", hero_valid, 1'b0);
    check("rst_hero_beat", hero_beat, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_errs", {proto_err, timeout_err}, 2'b00);
    rst = 0;

    // Single requester, three beats; clk_en must be forced to 1.
    beat_cyc.delete();
    send(0, T_VALID, 36'h1, 1'b0); send(0, T_VALID, 36'h2, 1'b0); send(0, T_DONE, 36'h3, 1'b1);
    expect_beat(T_VALID, 36'h1); expect_beat(T_VALID, 36'h2); expect_beat(T_DONE, 36'h3);
    @(negedge clk);
    @(negedge clk); #3;
    check("t1_busy", busy, 1'b1);
    check("t1_grant", grant_id, 2'd0);
    wait_beats(3, "t1_beats_seen");
    check("t1_busy_drop", busy, 1'b0);
    check("t1_consecutive", beat_cyc[2] - beat_cyc[0], 2);
    wait_idle("t1_idle");

    // Contention from reset: order 0,1,2,3,0 with one bubble per transaction.
    do_reset();
    beat_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      send(i, T_VALID, 36'h100 + 36'(i * 16), 1'b1);
      send(i, T_DONE,  36'h101 + 36'(i * 16), 1'b1);
    end
    send(0, T_VALID, 36'h1A0, 1'b1); send(0, T_DONE, 36'h1A1, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) begin
      expect_beat(T_VALID, 36'h100 + 36'(i * 16));
      expect_beat(T_DONE,  36'h101 + 36'(i * 16));
    end
    expect_beat(T_VALID, 36'h1A0); expect_beat(T_DONE, 36'h1A1);
    wait_idle("t2_idle");
    check("t2_beat_count", beat_cyc.size(), 10);
    check("t2_span", (beat_cyc.size() == 10) ? beat_cyc[9] - beat_cyc[0] : -1, 13);

    // Backpressure: 5 stalled cycles mid-transaction.
    beat_cyc.delete();
    send(1, T_VALID, 36'h211, 1'b1); send(1, T_VALID, 36'h212, 1'b1);
    send(1, T_VALID, 36'h213, 1'b1); send(1, T_DONE, 36'h214, 1'b1);
    expect_beat(T_VALID, 36'h211); expect_beat(T_VALID, 36'h212);
    expect_beat(T_VALID, 36'h213); expect_beat(T_DONE, 36'h214);
    wait_beats(1, "t3_first_beat");
    stall_cnt = 5;
    @(negedge clk);
    @(negedge clk); #3;
    check("t3_ready_blocked", req_ready[1], 1'b0);
    check("t3_out_full", hero_valid, 1'b1);
    wait_idle("t3_idle");
    check("t3_beat_count", beat_cyc.size(), 4);

    // Owner presents IDLE: swallowed, proto_err sticky, grant kept over req0.
    send(2, T_VALID, 36'h321, 1'b1); send(2, T_IDLE, 36'h322, 1'b1);
    send(2, T_VALID, 36'h323, 1'b1); send(2, T_DONE, 36'h324, 1'b1);
    send(0, T_DONE, 36'h372, 1'b1);
    expect_beat(T_VALID, 36'h321); expect_beat(T_VALID, 36'h323); expect_beat(T_DONE, 36'h324);
    expect_beat(T_DONE, 36'h372);
    begin
      int n = 0;
      while (!proto_err && n < 50) begin
        @(negedge clk); #3;
        n++;
      end
    end
    check("t4_proto_set", proto_err, 1'b1);
    check("t4_grant_kept", grant_id, 2'd2);
    check("t4_busy", busy, 1'b1);
    wait_idle("t4_idle");
    check("t4_proto_sticky", proto_err, 1'b1);

    // Reset after first of three beats from req3; rr_ptr must restart at 0.
    beat_cyc.delete();
    send(3, T_VALID, 36'h441, 1'b1); send(3, T_VALID, 36'h442, 1'b1); send(3, T_DONE, 36'h443, 1'b1);
    expect_beat(T_VALID, 36'h441);
    wait_beats(1, "t5_first_beat");
    rst = 1;
    @(negedge clk); #3;
    check("t5_hero_valid", hero_valid, 1'b0);
    check("t5_hero_beat", hero_beat, '0);
    check("t5_busy", busy, 1'b0);
    check("t5_grant", grant_id, 2'd0);
    check("t5_proto_cleared", proto_err, 1'b0);
    rst = 0;
    beat_cyc.delete();
    send(3, T_DONE, 36'h582, 1'b1); send(0, T_DONE, 36'h581, 1'b1);
    expect_beat(T_DONE, 36'h581); expect_beat(T_DONE, 36'h582);
    @(negedge clk);
    @(negedge clk); #3;
    check("t5_regrant", grant_id, 2'd0);
    wait_idle("t5_idle");
    check("t5_single_beat_gap", (beat_cyc.size() == 2) ? beat_cyc[1] - beat_cyc[0] : -1, 2);

`ifdef HERO_WRITE_ARB_TIMEOUT_EN
    // Owner stalls after one beat: DONE with wdat=0 injected, then req3 served.
    beat_cyc.delete();
    send(2, T_VALID, 36'h651, 1'b1);
    send(3, T_DONE, 36'h661, 1'b1);
    expect_beat(T_VALID, 36'h651); expect_beat(T_DONE, 36'h0); expect_beat(T_DONE, 36'h661);
    wait_idle("t6_idle");
    check("t6_timeout_err", timeout_err, 1'b1);
    check("t6_inject_gap", (beat_cyc.size() == 3) ? beat_cyc[1] - beat_cyc[0] : -1, 9);
`else
    check("no_timeout_err", timeout_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
